// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front-end feeding the IF/ID register.
// Owns the fetch PC and issues one outstanding request at a time to a
// variable-latency instruction memory. Returned words are queued with their
// PCs and handed to decode over a valid/ready handshake. Jump redirects
// flush the queue and squash an in-flight fetch. Halt is sticky until reset.
module fetch_queue #(
  parameter int                    PC_WIDTH    = 15,
  parameter int                    INSTR_WIDTH = 16,
  parameter int                    DEPTH       = 4,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          redirect,
  input  logic [PC_WIDTH-1:0]           redirect_pc,
  input  logic                          halt,
  output logic                          imem_req,
  output logic [PC_WIDTH-1:0]           imem_addr,
  input  logic                          imem_ack,
  input  logic [INSTR_WIDTH-1:0]        imem_rdata,
  output logic                          id_valid,
  input  logic                          id_ready,
  output logic [INSTR_WIDTH-1:0]        id_instr,
  output logic [PC_WIDTH-1:0]           id_pc,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          halted
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,   // nothing outstanding
    ST_WAIT,   // request outstanding, its ack will be pushed
    ST_DRAIN,  // request outstanding but squashed, its ack is dropped
    ST_HALT    // halt latched, nothing outstanding
  } state_t;

  state_t                 state_reg, state_next;
  logic [PC_WIDTH-1:0]    fetch_pc_reg, fetch_pc_next;
  logic                   halt_latch_reg, halt_latch_next;
  logic [PW-1:0]          rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]          count_reg;

  logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];

  logic redirect_eff;
  logic fifo_full;
  logic fifo_empty;
  logic issue;
  logic push;
  logic pop;
  logic go_halt;

  // Redirect is meaningless once halted; everything else treats it as top priority.
  assign redirect_eff    = redirect & (state_reg != ST_HALT);
  assign fifo_full       = (count_reg == CW'(DEPTH));
  assign fifo_empty      = (count_reg == '0);
  assign halt_latch_next = halt_latch_reg | halt;
  assign go_halt         = halt_latch_next;

  // Only issue from IDLE, with room for the answer and no halt/redirect in play.
  // Since at most one request is outstanding, a push never finds the FIFO full.
  assign issue = (state_reg == ST_IDLE) & ~fifo_full & ~halt_latch_reg & ~halt & ~redirect;
  assign push  = (state_reg == ST_WAIT) & imem_ack & ~redirect_eff;
  assign pop   = ~fifo_empty & id_ready & ~redirect_eff;

  assign imem_req  = issue & ~reset;
  assign imem_addr = fetch_pc_reg;
  assign id_valid  = ~fifo_empty;
  assign id_instr  = fifo_empty ? '0 : instr_mem[rd_ptr_reg];
  assign id_pc     = fifo_empty ? '0 : pc_mem[rd_ptr_reg];
  assign count     = count_reg;
  assign halted    = (state_reg == ST_HALT);

  // Next-state and next fetch PC.
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    case (state_reg)
      ST_IDLE: begin
        if (redirect) begin
          fetch_pc_next = redirect_pc;
        end
        if (go_halt) begin
          state_next = ST_HALT;
        end else if (issue) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          fetch_pc_next = redirect_pc;
          // An ack in the redirect cycle is simply dropped; otherwise wait it out.
          if (imem_ack) begin
            state_next = go_halt ? ST_HALT : ST_IDLE;
          end else begin
            state_next = ST_DRAIN;
          end
        end else if (imem_ack) begin
          fetch_pc_next = fetch_pc_reg + PC_WIDTH'(1);
          state_next    = go_halt ? ST_HALT : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (redirect) begin
          fetch_pc_next = redirect_pc;
        end
        // The squashed request's ack ends the drain even if a new redirect arrives.
        if (imem_ack) begin
          state_next = go_halt ? ST_HALT : ST_IDLE;
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Control state: FSM, fetch PC and the sticky halt latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      fetch_pc_reg   <= RESET_PC;
      halt_latch_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fetch_pc_reg   <= fetch_pc_next;
      halt_latch_reg <= halt_latch_next;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue outright.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (redirect_eff) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= fetch_pc_reg;
      instr_mem[wr_ptr_reg] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven, directed and randomized checks of fetch_queue
// against a queue-based reference model and a latency-programmable memory.
module tb_fetch_queue;

  localparam int PW    = 15;
  localparam int IW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          redirect;
  logic [PW-1:0] redirect_pc;
  logic          halt;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic          id_valid;
  logic          id_ready;
  logic [IW-1:0] id_instr;
  logic [PW-1:0] id_pc;
  logic [CW-1:0] count;
  logic          halted;

  always #5 clk = ~clk;

  fetch_queue #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .count(count), .halted(halted)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [IW-1:0] instr_of(logic [PW-1:0] a);
    return IW'({1'b0, a} * 16'd37) ^ 16'hC3A5;
  endfunction

  // Reference model: a queue of fetched words plus the fetch PC and three flags.
  typedef struct {
    logic [PW-1:0] pc;
    logic [IW-1:0] instr;
  } entry_t;
  entry_t        q[$];
  logic [PW-1:0] m_pc;
  bit            m_out;    // a request is in flight
  bit            m_sq;     // the in-flight request has been squashed
  bit            m_latch;  // halt seen since reset

  // Memory model: one pending request answered after lat cycles.
  bit            mem_pend;
  logic [PW-1:0] mem_addr;
  int            mem_cd;
  int            lat = 1;

  // Outputs sampled in the most recent step.
  logic          last_req, last_valid, last_halted;
  logic [PW-1:0] last_addr, last_pc;
  logic [IW-1:0] last_instr;
  logic [CW-1:0] last_count;

  task automatic model_reset();
    q.delete();
    m_pc     = '0;
    m_out    = 0;
    m_sq     = 0;
    m_latch  = 0;
    mem_pend = 0;
    mem_cd   = 0;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, " imem_req"},  32'(imem_req),  32'd0);
    check({tag, " imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, " id_valid"},  32'(id_valid),  32'd0);
    check({tag, " id_pc"},     32'(id_pc),     32'd0);
    check({tag, " id_instr"},  32'(id_instr),  32'd0);
    check({tag, " count"},     32'(count),     32'd0);
    check({tag, " halted"},    32'(halted),    32'd0);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    halt        = 1'b0;
    id_ready    = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic async_reset_mid();
    #2;
    reset    = 1'b1;
    redirect = 1'b0;
    halt     = 1'b0;
    id_ready = 1'b0;
    imem_ack = 1'b0;
    #1;
    check_reset_outputs("async reset");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One clock cycle: drive inputs, answer memory, compare against the model.
  task automatic step(input bit rd, input logic [PW-1:0] rpc, input bit hl, input bit rdy);
    bit exp_req, red_eff, do_pop, ack_now;
    redirect    = rd;
    redirect_pc = rpc;
    halt        = hl;
    id_ready    = rdy;
    imem_ack    = 1'b0;
    imem_rdata  = IW'($urandom);
    if (mem_pend) begin
      mem_cd--;
      if (mem_cd <= 0) begin
        imem_ack   = 1'b1;
        imem_rdata = instr_of(mem_addr);
        mem_pend   = 0;
      end
    end
    ack_now = imem_ack;
    @(negedge clk);
    exp_req = !m_out && !m_latch && !hl && !rd && (q.size() < DEPTH);
    check("imem_req",  32'(imem_req),  32'(exp_req));
    check("imem_addr", 32'(imem_addr), 32'(m_pc));
    check("id_valid",  32'(id_valid),  32'(q.size() > 0));
    check("id_pc",     32'(id_pc),     (q.size() > 0) ? 32'(q[0].pc) : 32'd0);
    check("id_instr",  32'(id_instr),  (q.size() > 0) ? 32'(q[0].instr) : 32'd0);
    check("count",     32'(count),     32'(q.size()));
    check("halted",    32'(halted),    32'(m_latch && !m_out));
    last_req    = imem_req;
    last_addr   = imem_addr;
    last_valid  = id_valid;
    last_pc     = id_pc;
    last_instr  = id_instr;
    last_count  = count;
    last_halted = halted;
    // Advance the model by the rules of the block.
    red_eff = rd && !(m_latch && !m_out);
    do_pop  = (q.size() > 0) && rdy && !red_eff;
    if (red_eff) begin
      q.delete();
      m_pc = rpc;
      if (m_out) begin
        if (ack_now) begin
          m_out = 0;
          m_sq  = 0;
        end else begin
          m_sq = 1;
        end
      end
    end else begin
      if (do_pop) void'(q.pop_front());
      if (m_out && ack_now) begin
        if (m_sq) begin
          m_sq = 0;
        end else begin
          q.push_back('{m_pc, imem_rdata});
          m_pc = m_pc + 1'b1;
        end
        m_out = 0;
      end
    end
    if (exp_req) m_out = 1;
    if (hl) m_latch = 1;
    if (imem_req) begin
      mem_pend = 1;
      mem_addr = imem_addr;
      mem_cd   = lat;
    end
    $display("cyc rd=%0b hl=%0b rdy=%0b ack=%0b | req=%0b addr=%0h valid=%0b pc=%0h count=%0d halted=%0b",
             rd, hl, rdy, ack_now, last_req, last_addr, last_valid, last_pc, last_count, last_halted);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit            exp_req;
    logic [PW-1:0] exp_addr;
    bit            exp_valid;
    logic [PW-1:0] exp_pc;
    logic [CW-1:0] exp_count;
  } vec_t;

  vec_t tbl[9];

  initial begin
    bit found;
    // Reset -> PC stream at latency 1 with decode always ready.
    tbl[0] = '{1'b1, 15'd0, 1'b0, 15'd0, 3'd0};
    tbl[1] = '{1'b0, 15'd0, 1'b0, 15'd0, 3'd0};
    tbl[2] = '{1'b1, 15'd1, 1'b1, 15'd0, 3'd1};
    tbl[3] = '{1'b0, 15'd1, 1'b0, 15'd0, 3'd0};
    tbl[4] = '{1'b1, 15'd2, 1'b1, 15'd1, 3'd1};
    tbl[5] = '{1'b0, 15'd2, 1'b0, 15'd0, 3'd0};
    tbl[6] = '{1'b1, 15'd3, 1'b1, 15'd2, 3'd1};
    tbl[7] = '{1'b0, 15'd3, 1'b0, 15'd0, 3'd0};
    tbl[8] = '{1'b1, 15'd4, 1'b1, 15'd3, 3'd1};

    do_reset();
    lat = 1;
    for (int i = 0; i < 9; i++) begin
      step(0, '0, 0, 1);
      check("tbl req",   32'(last_req),   32'(tbl[i].exp_req));
      check("tbl addr",  32'(last_addr),  32'(tbl[i].exp_addr));
      check("tbl valid", 32'(last_valid), 32'(tbl[i].exp_valid));
      check("tbl pc",    32'(last_pc),    32'(tbl[i].exp_pc));
      check("tbl count", 32'(last_count), 32'(tbl[i].exp_count));
      if (tbl[i].exp_valid)
        check("tbl instr", 32'(last_instr), 32'(instr_of(tbl[i].exp_pc)));
    end

    // Backpressure: four pushes fill the queue, then one pop frees a slot.
    do_reset();
    lat = 1;
    for (int i = 0; i < 8; i++) step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    check("bp full count", 32'(last_count), 32'd4);
    check("bp full req",   32'(last_req),   32'd0);
    step(0, '0, 0, 1);
    step(0, '0, 0, 0);
    check("bp count after pop", 32'(last_count), 32'd3);
    check("bp next req",        32'(last_req),   32'd1);
    check("bp next addr",       32'(last_addr),  32'd4);
    // Async reset with three entries queued and a request in flight.
    async_reset_mid();

    // Redirect while a latency-3 request for address 5 is in flight.
    lat = 3;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step(0, '0, 0, 1);
      if (last_req && last_addr == 15'd5) found = 1;
    end
    check("redir saw addr5", 32'(found), 32'd1);
    step(1, 15'h040, 0, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, '0, 0, 1);
      if (last_req) found = 1;
    end
    check("redir new req",  32'(found),     32'd1);
    check("redir new addr", 32'(last_addr), 32'h040);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, '0, 0, 1);
      if (last_valid) found = 1;
    end
    check("redir head seen", 32'(found),   32'd1);
    check("redir head pc",   32'(last_pc), 32'h040);

    // Redirect coincident with an ack and a pop while two entries are queued.
    do_reset();
    lat = 1;
    for (int i = 0; i < 5; i++) step(0, '0, 0, 0);
    check("coinc count before", 32'(last_count), 32'd2);
    step(1, 15'h1234, 0, 1);
    step(0, '0, 0, 1);
    check("coinc count", 32'(last_count), 32'd0);
    check("coinc valid", 32'(last_valid), 32'd0);
    check("coinc req",   32'(last_req),   32'd1);
    check("coinc addr",  32'(last_addr),  32'h1234);

    // Halt while address 7 is in flight.
    do_reset();
    lat = 2;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step(0, '0, 0, 1);
      if (last_req && last_addr == 15'd7) found = 1;
    end
    check("halt saw addr7", 32'(found), 32'd1);
    step(0, '0, 1, 0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(0, '0, 0, 0);
      if (last_halted) found = 1;
    end
    check("halt reached", 32'(found),      32'd1);
    check("halt count",   32'(last_count), 32'd1);
    check("halt head pc", 32'(last_pc),    32'd7);
    for (int i = 0; i < 20; i++) begin
      step(i == 5, 15'h055, 0, 0);
      check("halt no req", 32'(last_req), 32'd0);
    end
    check("halt redirect ignored count", 32'(last_count), 32'd1);
    check("halt redirect ignored addr",  32'(last_addr),  32'd8);
    step(0, '0, 0, 1);
    step(0, '0, 0, 0);
    check("halt drained count", 32'(last_count),  32'd0);
    check("halt still halted",  32'(last_halted), 32'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (m_latch && !m_out && $urandom_range(0, 29) == 0) begin
        do_reset();
      end
      lat = int'($urandom_range(1, 4));
      step($urandom_range(0, 19) == 0, PW'($urandom), $urandom_range(0, 499) == 0,
           $urandom_range(0, 9) < 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front-end that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues single-outstanding requests to a variable-latency instruction memory port.
- Buffers returned instructions with their PCs in a small FIFO and presents them to the decode stage with a valid/ready handshake.
- Handles jump redirects, which flush the queue and squash any in-flight fetch, and a sticky halt.

Parameters:
- PC_WIDTH, 15, width of fetch PC and of instruction address.
- INSTR_WIDTH, 16, width of instruction word.
- DEPTH, 4, FIFO entries; must be a power of two, ≥2.
- RESET_PC, 0, fetch PC loaded on reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- redirect  in  1  jump request (ldpc from ID); one-cycle pulse.
- redirect_pc  in  PC_WIDTH  jump target, sampled when redirect=1.
- halt  in  1  stop fetching; latched, sticky until reset.
- imem_req  out  1  one-cycle request pulse to instruction memory.
- imem_addr  out  PC_WIDTH  request address, equal to fetch_pc.
- imem_ack  in  1  one-cycle response strobe, ≥1 cycle after imem_req.
- imem_rdata  in  INSTR_WIDTH  instruction data, valid when imem_ack=1.
- id_valid  out  1  head entry available.
- id_ready  in  1  decode accepts head (i.e. not stalled).
- id_instr  out  INSTR_WIDTH  head instruction; 0 when id_valid=0.
- id_pc  out  PC_WIDTH  head PC; 0 when id_valid=0.
- count  out  $clog2(DEPTH+1)  current FIFO occupancy.
- halted  out  1  halt latched and no fetch outstanding.

Behaviour:
- Reset (async, active-high): fetch_pc=RESET_PC, FSM=IDLE, FIFO empty, halt latch=0. All outputs 0 except imem_addr=RESET_PC.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
  - DRAIN: outstanding request has been squashed.
  - HALT: halt latched, nothing outstanding.
- IDLE:
  - imem_req=1 (combinational) iff count<DEPTH, halt latch=0, halt=0 and redirect=0 this cycle.
  - Issuing moves the FSM to WAIT.
  - Maximum one outstanding request, so an ack always has room.
- WAIT, on imem_ack:
  - Push {fetch_pc, imem_rdata}.
  - fetch_pc += 1, wrapping mod 2^PC_WIDTH.
  - Go to IDLE, or to HALT if the halt latch is set.
  - The next request is issued no earlier than the following cycle (peak throughput 1 instruction / 2 cycles at 1-cycle latency).
- Redirect, highest priority (ignored in HALT):
  - FIFO cleared (count=0); any pop or push in the same cycle is discarded.
  - fetch_pc=redirect_pc.
  - From WAIT with no ack in the same cycle, go to DRAIN.
  - From WAIT with an ack in the same cycle, the ack is dropped and the FSM goes to IDLE.
  - In DRAIN: fetch_pc is updated, state stays DRAIN.
- DRAIN: the next imem_ack is discarded (no push, PC unchanged), then go to IDLE, or to HALT if latched.
- Halt:
  - halt=1 sets the latch and blocks requests in the same cycle.
  - From IDLE, go to HALT next cycle.
  - From WAIT, the in-flight ack still pushes, then go to HALT.
  - halted=1 in HALT.
  - FIFO contents remain poppable in HALT.
- Pop: occurs when id_valid & id_ready & ~redirect.
- Occupancy: count = count + push − pop, so simultaneous push and pop keeps count.
- FIFO layout:
  - Circular read/write pointers of $clog2(DEPTH) bits that wrap naturally.
  - Head outputs are driven combinationally from storage, gated to 0 when empty.
- Reset mid-WAIT: the state is dropped. The memory model must not deliver a stale ack after reset release (bench responsibility).

Test Plan:
- Reset → PC stream, memory latency 1, id_ready=1: imem_addr 0,1,2,3 on successive requests; id_pc/id_instr stream 0..3 with matching data; count never exceeds 1.
- Backpressure: id_ready=0, latency 1 → four pushes, count=4, imem_req stays 0; then id_ready=1 for one cycle → count=3, next request addr=4.
- Redirect while WAIT, latency 3: request addr=5 outstanding, redirect=1, redirect_pc=0x040 → FIFO flushed; the ack for addr 5 is discarded; next request addr=0x040, and the first id_pc after it is 0x040.
- Redirect coincident with ack and with pop (count=2): count=0 next cycle; no push; next imem_addr=redirect_pc.
- Halt during WAIT:
  - halt pulse while addr=7 is in flight → the ack pushes PC 7, then halted=1 and no further imem_req for 20 cycles.
  - Queue drains to count=0 via id_ready.
  - redirect in HALT has no effect.
- Async reset asserted mid-stream with count=3 → count=0, id_valid=0, imem_addr=RESET_PC immediately, without waiting for a clock edge.
